regfile_scoreboard: RTL and testbench

Parametrised multi-port register file with a per-register busy scoreboard, the next-generation register store for the CPU datapath. It provides NR combinational read ports, NW clocked write ports with write-to-read bypass, an optional hardwired-zero register 0, and busy tracking. The decode stage uses busy tracking to stall on operands whose producing instruction has not yet written back.

---
 rtl/regfile_scoreboard.sv | 94 +++++++++
 tb/tb_regfile_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with per-register busy scoreboard
// Combinational reads with optional same-cycle write forwarding; issue marks a register busy until writeback.
module regfile_scoreboard #(
  parameter int B        = 32,
  parameter int N        = 5,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NR*N-1:0] r_addr,
  output logic [NR*B-1:0] r_data,
  output logic [NR-1:0]   r_busy,
  input  logic [NW-1:0]   w_en,
  input  logic [NW*N-1:0] w_addr,
  input  logic [NW*B-1:0] w_data,
  input  logic            iss_en,
  input  logic [N-1:0]    iss_addr,
  output logic            iss_ready,
  output logic [N:0]      busy_cnt
);
  localparam int D = 1 << N;

  logic [B-1:0]  mem [D];
  logic [D-1:0]  busy;
  logic [D-1:0]  wr_hit;
  logic [D-1:0]  fwd_hit;
  logic [D-1:0]  busy_eff;
  logic [D-1:0]  busy_nxt;
  logic [NW-1:0] w_live;
  logic [N:0]    cnt_nxt;

  // Pending writes are masked in reset so forwarding cannot leak data while storage reads as zero.
  assign w_live = w_en & {NW{rst_n}};

  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NW; j++) begin
      if (w_live[j]) wr_hit[w_addr[j*N +: N]] = 1'b1;
    end
  end

  assign fwd_hit = (BYPASS != 0) ? wr_hit : '0;

  always_comb begin
    busy_eff = busy & ~fwd_hit;
    if (ZERO_REG != 0) busy_eff[0] = 1'b0;
  end

  assign iss_ready = ~busy_eff[iss_addr];

  // Issue is applied after writeback clears so a same-cycle producer leaves the register busy.
  always_comb begin
    busy_nxt = busy & ~wr_hit;
    if (iss_en && iss_ready) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < D; i++) begin
      cnt_nxt = cnt_nxt + {{N{1'b0}}, busy_nxt[i]};
    end
  end

  always_comb begin
    r_data = '0;
    r_busy = '0;
    for (int k = 0; k < NR; k++) begin
      r_data[k*B +: B] = mem[r_addr[k*N +: N]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NW; j++) begin
          if (w_live[j] && (w_addr[j*N +: N] == r_addr[k*N +: N])) r_data[k*B +: B] = w_data[j*B +: B];
        end
      end
      if ((ZERO_REG != 0) && (r_addr[k*N +: N] == '0)) r_data[k*B +: B] = '0;
      r_busy[k] = busy_eff[r_addr[k*N +: N]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (w_en[j] && !((ZERO_REG != 0) && (w_addr[j*N +: N] == '0)))
          mem[w_addr[j*N +: N]] <= w_data[j*B +: B];
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized and directed self-checking bench for regfile_scoreboard
// Reference model: plain arrays of register values and busy flags updated by the register-file rules.
module tb_regfile_scoreboard;
  localparam int B  = 32;
  localparam int N  = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int D  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*N-1:0] r_addr = '0;
  logic [NR*B-1:0] r_data;
  logic [NR-1:0]   r_busy;
  logic [NW-1:0]   w_en = '0;
  logic [NW*N-1:0] w_addr = '0;
  logic [NW*B-1:0] w_data = '0;
  logic            iss_en = 1'b0;
  logic [N-1:0]    iss_addr = '0;
  logic            iss_ready;
  logic [N:0]      busy_cnt;

  int checks = 0;
  int failures = 0;
  logic [B-1:0] m_mem [D];
  bit           m_busy [D];

  always #5 clk = ~clk;

  regfile_scoreboard #(.B(B), .N(N), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .busy_cnt(busy_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit written(input int a);
    for (int j = 0; j < NW; j++)
      if (w_en[j] && int'(w_addr[j*N +: N]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_busy(input int a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !written(a);
  endfunction

  function automatic logic [B-1:0] exp_read(input int a);
    logic [B-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
    for (int j = 0; j < NW; j++)
      if (w_en[j] && int'(w_addr[j*N +: N]) == a) v = w_data[j*B +: B];
    return v;
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    w_en   = '0;
    iss_en = 1'b0;
  endtask

  // Called just after a falling edge with inputs driven; checks outputs, then advances one clock.
  task automatic step();
    bit accept;
    int ia;
    #1;
    for (int k = 0; k < NR; k++) begin
      chk("r_data", 64'(r_data[k*B +: B]), 64'(exp_read(int'(r_addr[k*N +: N]))));
      chk("r_busy", 64'(r_busy[k]), 64'(exp_busy(int'(r_addr[k*N +: N]))));
    end
    ia = int'(iss_addr);
    accept = !exp_busy(ia);
    chk("iss_ready", 64'(iss_ready), 64'(accept));
    chk("busy_cnt", 64'(busy_cnt), 64'(exp_count()));
    @(posedge clk);
    for (int j = 0; j < NW; j++) begin
      if (w_en[j] && w_addr[j*N +: N] != '0) begin
        m_mem[int'(w_addr[j*N +: N])]  = w_data[j*B +: B];
        m_busy[int'(w_addr[j*N +: N])] = 1'b0;
      end
    end
    if (iss_en && accept && ia != 0) m_busy[ia] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    #1;
    chk("rst_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_ready", 64'(iss_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two ports to one address: port 1 wins both through bypass and in storage.
    w_en = 2'b11; w_addr = {5'd5, 5'd5}; w_data = {32'h0000_5555, 32'hAAAA_0000};
    r_addr = {5'd0, 5'd5};
    #1 chk("prio_bypass", 64'(r_data[B-1:0]), 64'h0000_5555);
    step();
    idle();
    #1 chk("prio_mem", 64'(r_data[B-1:0]), 64'h0000_5555);
    step();

    // Register 0 is hardwired.
    w_en = 2'b01; w_addr = {5'd0, 5'd0}; w_data = {32'h0, 32'hDEAD_BEEF}; r_addr = '0;
    step();
    idle();
    #1 chk("zero_read", 64'(r_data[B-1:0]), 64'd0);
    iss_en = 1'b1; iss_addr = 5'd0;
    #1 chk("zero_iss_ready", 64'(iss_ready), 64'd1);
    step();
    idle();
    #1 chk("zero_iss_cnt", 64'(busy_cnt), 64'd0);
    step();

    // Issue then writeback on register 3.
    iss_en = 1'b1; iss_addr = 5'd3;
    step();
    idle(); r_addr = {5'd0, 5'd3};
    #1 chk("iss3_busy", 64'(r_busy[0]), 64'd1);
    chk("iss3_cnt", 64'(busy_cnt), 64'd1);
    chk("iss3_ready", 64'(iss_ready), 64'd0);
    w_en = 2'b01; w_addr = {5'd0, 5'd3}; w_data = {32'h0, 32'h1234_0003};
    #1 chk("wb3_busy_bypass", 64'(r_busy[0]), 64'd0);
    step();
    idle();
    #1 chk("wb3_cnt", 64'(busy_cnt), 64'd0);
    step();

    // Same-cycle writeback and reissue of register 7: set wins.
    iss_en = 1'b1; iss_addr = 5'd7;
    step();
    idle();
    w_en = 2'b10; w_addr = {5'd7, 5'd0}; w_data = {32'h7777_7777, 32'h0};
    iss_en = 1'b1; iss_addr = 5'd7;
    #1 chk("set_clr_ready", 64'(iss_ready), 64'd1);
    step();
    idle(); r_addr = {5'd7, 5'd7};
    #1 chk("set_clr_busy", 64'(r_busy[1]), 64'd1);
    chk("set_clr_cnt", 64'(busy_cnt), 64'd1);
    step();

    // Random traffic with addresses concentrated to force collisions.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NR; k++)
        r_addr[k*N +: N] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      for (int j = 0; j < NW; j++) begin
        w_en[j] = ($urandom_range(0, 2) == 0);
        w_addr[j*N +: N] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        w_data[j*B +: B] = $urandom;
      end
      iss_en = ($urandom_range(0, 1) == 1);
      iss_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      step();
    end

    // Asynchronous reset between edges with preloaded, busy state.
    idle();
    w_en = 2'b11; w_addr = {5'd10, 5'd9}; w_data = {32'hCAFE_0010, 32'hBEEF_0009};
    step();
    idle(); iss_en = 1'b1; iss_addr = 5'd12;
    step();
    idle(); r_addr = {5'd10, 5'd9};
    #1 rst_n = 1'b0;
    #1 chk("async_rd0", 64'(r_data[B-1:0]), 64'd0);
    chk("async_rd1", 64'(r_data[2*B-1:B]), 64'd0);
    chk("async_cnt", 64'(busy_cnt), 64'd0);
    chk("async_ready", 64'(iss_ready), 64'd1);
    model_clear();
    for (int a = 0; a < D; a++) begin
      r_addr = {5'(a), 5'(a)};
      #1 chk("rst_sweep", 64'(r_data), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill every non-zero register, then confirm further issues are refused.
    for (int a = 1; a < D; a++) begin
      iss_en = 1'b1; iss_addr = 5'(a);
      step();
    end
    idle();
    #1 chk("fill_cnt", 64'(busy_cnt), 64'd31);
    for (int a = 0; a < D; a++) begin
      iss_en = 1'b1; iss_addr = 5'(a); r_addr = {5'(a), 5'(a)};
      #1 chk("fill_ready", 64'(iss_ready), (a == 0) ? 64'd1 : 64'd0);
      chk("fill_busy", 64'(r_busy[0]), (a == 0) ? 64'd0 : 64'd1);
      step();
    end
    idle();
    #1 chk("fill_cnt_hold", 64'(busy_cnt), 64'd31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
